// File: rtl/prim_esc_ping_array.sv
// Multi-channel escalation link harness: NumCh sender/receiver pairs with per-wire fault
// injection, a round-robin ping sweeper with programmable timeout, and sticky failure status.
module prim_esc_ping_array #(
  parameter  int unsigned NumCh    = 4,
  parameter  int unsigned TimeoutW = 8,
  localparam int unsigned ChW      = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumCh-1:0]    resp_err_pi,
  input  logic [NumCh-1:0]    resp_err_ni,
  input  logic [NumCh-1:0]    esc_err_pi,
  input  logic [NumCh-1:0]    esc_err_ni,
  input  logic [NumCh-1:0]    esc_en_i,
  input  logic                ping_start_i,
  input  logic [TimeoutW-1:0] ping_timeout_i,
  input  logic                clr_i,
  output logic [NumCh-1:0]    esc_en_o,
  output logic [NumCh-1:0]    integ_fail_o,
  output logic [NumCh-1:0]    integ_fail_sticky_o,
  output logic [NumCh-1:0]    ping_timeout_o,
  output logic                ping_busy_o,
  output logic                ping_done_o,
  output logic [ChW-1:0]      ping_ch_o
);

  // Sweeper states:
  //   SwIdle | waiting for ping_start_i, ch and cnt held at 0
  //   SwPing | pinging channel ch (or skipping it if it is escalating)
  //   SwNext | advance to the next channel or finish
  //   SwDone | one-cycle done pulse
  typedef enum logic [1:0] {SwIdle, SwPing, SwNext, SwDone} sw_state_e;
  typedef enum logic [1:0] {TxIdle, TxPing, TxWait, TxEsc} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxCheck, RxEsc} rx_state_e;

  logic [NumCh-1:0] ping_en;
  logic [NumCh-1:0] ping_ok;
  logic [NumCh-1:0] integ_fail;
  logic [NumCh-1:0] esc_en;

  // A ping is a single-cycle pulse on esc_p; escalation holds esc_p for two or more cycles.
  // Wire pairs are {P, N}; equal P and N on either pair signals an integrity failure.
  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    tx_state_e  tx_state_q, tx_state_d;
    rx_state_e  rx_state_q, rx_state_d;
    logic [1:0] resp_q, resp_d;
    logic [1:0] esc_tx, esc_rx;
    logic       tx_active;
    logic       sigint;

    assign tx_active = (tx_state_q == TxPing) || (tx_state_q == TxEsc);
    assign esc_tx    = {tx_active, ~tx_active} ^ {esc_err_pi[i], esc_err_ni[i]};
    assign esc_rx    = resp_q ^ {resp_err_pi[i], resp_err_ni[i]};
    assign sigint    = (esc_tx[1] == esc_tx[0]);

    assign integ_fail[i] = (esc_rx[1] == esc_rx[0]);
    assign ping_ok[i]    = (tx_state_q == TxWait) && (esc_rx == 2'b10);
    assign esc_en[i]     = (rx_state_q == RxEsc);

    always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
        TxIdle: begin
          if (esc_en_i[i]) begin
            tx_state_d = TxEsc;
          end else if (ping_en[i]) begin
            tx_state_d = TxPing;
          end
        end
        TxPing: tx_state_d = TxWait;
        TxWait: tx_state_d = esc_en_i[i] ? TxEsc : TxIdle;
        TxEsc: begin
          if (!esc_en_i[i]) begin
            tx_state_d = TxIdle;
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end

    // On a corrupted escalation pair the receiver answers with equal response wires so the
    // sender sees the failure too.
    always_comb begin
      rx_state_d = rx_state_q;
      resp_d     = 2'b01;
      if (sigint) begin
        rx_state_d = RxIdle;
        resp_d     = 2'b11;
      end else begin
        case (rx_state_q)
          RxIdle: begin
            if (esc_tx[1]) begin
              rx_state_d = RxCheck;
              resp_d     = 2'b10;
            end
          end
          RxCheck: begin
            if (esc_tx[1]) begin
              rx_state_d = RxEsc;
              resp_d     = {~resp_q[1], resp_q[1]};
            end else begin
              rx_state_d = RxIdle;
            end
          end
          RxEsc: begin
            if (esc_tx[1]) begin
              resp_d = {~resp_q[1], resp_q[1]};
            end else begin
              rx_state_d = RxIdle;
            end
          end
          default: rx_state_d = RxIdle;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tx_state_q <= TxIdle;
        rx_state_q <= RxIdle;
        resp_q     <= 2'b01;
      end else begin
        tx_state_q <= tx_state_d;
        rx_state_q <= rx_state_d;
        resp_q     <= resp_d;
      end
    end
  end

  sw_state_e           state_q, state_d;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [TimeoutW-1:0] cnt_q, cnt_d;
  logic [NumCh-1:0]    tmo_q, tmo_d, tmo_set;
  logic [NumCh-1:0]    integ_q, integ_d;
  logic                skip;

  // An escalating channel is only skipped when it is already escalating on PING entry.
  assign skip = (state_q == SwPing) && (cnt_q == '0) && esc_en_i[ch_q];

  always_comb begin
    ping_en = '0;
    if ((state_q == SwPing) && !skip) begin
      ping_en[ch_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    tmo_set = '0;
    case (state_q)
      SwIdle: begin
        ch_d  = '0;
        cnt_d = '0;
        if (ping_start_i) begin
          state_d = SwPing;
        end
      end
      SwPing: begin
        if (cnt_q != {TimeoutW{1'b1}}) begin
          cnt_d = cnt_q + TimeoutW'(1);
        end
        if (skip || ping_ok[ch_q]) begin
          state_d = SwNext;
        end else if ((ping_timeout_i != '0) && (cnt_q == ping_timeout_i - TimeoutW'(1))) begin
          tmo_set[ch_q] = 1'b1;
          state_d       = SwNext;
        end
      end
      SwNext: begin
        cnt_d = '0;
        if (ch_q == ChW'(NumCh - 1)) begin
          state_d = SwDone;
        end else begin
          ch_d    = ch_q + ChW'(1);
          state_d = SwPing;
        end
      end
      SwDone: begin
        ch_d    = '0;
        state_d = SwIdle;
      end
      default: state_d = SwIdle;
    endcase
    tmo_d   = (clr_i ? '0 : tmo_q) | tmo_set;
    integ_d = (clr_i ? '0 : integ_q) | integ_fail;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SwIdle;
      ch_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      integ_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      integ_q <= integ_d;
    end
  end

  assign esc_en_o            = esc_en;
  assign integ_fail_o        = integ_fail;
  assign integ_fail_sticky_o = integ_q;
  assign ping_timeout_o      = tmo_q;
  assign ping_busy_o         = (state_q != SwIdle);
  assign ping_done_o         = (state_q == SwDone);
  assign ping_ch_o           = ch_q;

endmodule

// File: tb/tb_prim_esc_ping_array.sv
// Scoreboard bench for prim_esc_ping_array: stimulus pushes per-sweep expectations computed
// from sweep rules, a monitor pops and compares them on every ping_done_o pulse.
module tb_prim_esc_ping_array;
  localparam int NCH    = 4;
  localparam int TW     = 8;
  localparam int OK_LAT = 3;  // PING cycles a healthy channel needs: request, ping pulse, reply

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  resp_err_pi, resp_err_ni, esc_err_pi, esc_err_ni, esc_en_i;
  logic            ping_start_i, clr_i;
  logic [TW-1:0]   ping_timeout_i;
  logic [NCH-1:0]  esc_en_o, integ_fail_o, integ_fail_sticky_o, ping_timeout_o;
  logic            ping_busy_o, ping_done_o;
  logic [1:0]      ping_ch_o;

  prim_esc_ping_array #(.NumCh(NCH), .TimeoutW(TW)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .resp_err_pi         (resp_err_pi),
    .resp_err_ni         (resp_err_ni),
    .esc_err_pi          (esc_err_pi),
    .esc_err_ni          (esc_err_ni),
    .esc_en_i            (esc_en_i),
    .ping_start_i        (ping_start_i),
    .ping_timeout_i      (ping_timeout_i),
    .clr_i               (clr_i),
    .esc_en_o            (esc_en_o),
    .integ_fail_o        (integ_fail_o),
    .integ_fail_sticky_o (integ_fail_sticky_o),
    .ping_timeout_o      (ping_timeout_o),
    .ping_busy_o         (ping_busy_o),
    .ping_done_o         (ping_done_o),
    .ping_ch_o           (ping_ch_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned    dur;
    logic [NCH-1:0] tmo;
    logic [NCH-1:0] integ;
    logic [NCH-1:0] esc;
    logic [31:0]    ord;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  int   n_sweeps = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Sweep outcome from the rules: skip = 2 cycles, healthy = OK_LAT+1, timeout T = T+1, DONE = 1.
  function automatic exp_t model(input logic [NCH-1:0] fm, input logic [NCH-1:0] em,
                                 input int unsigned t);
    exp_t e;
    e.dur   = 1;
    e.tmo   = '0;
    e.integ = fm;
    e.esc   = em;
    e.ord   = 0;
    for (int c = 0; c < NCH; c++) begin
      e.ord = (e.ord << 4) | 32'(c);
      if (em[c]) begin
        e.dur += 2;
      end else if (fm[c] || (t != 0 && t < OK_LAT)) begin
        e.dur    += t + 1;
        e.tmo[c] = 1'b1;
      end else begin
        e.dur += OK_LAT + 1;
      end
    end
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int unsigned busy_cnt;
    logic [31:0] ord;
    int          last;
    logic        prev_done;
    exp_t        e;
    busy_cnt  = 0;
    ord       = 0;
    last      = -1;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt  = 0;
        ord       = 0;
        last      = -1;
        prev_done = 1'b0;
      end else begin
        if (ping_busy_o) begin
          busy_cnt++;
          if (int'(ping_ch_o) != last) begin
            ord  = (ord << 4) | 32'(ping_ch_o);
            last = int'(ping_ch_o);
          end
        end
        if (ping_done_o) begin
          n_done++;
          chk("done_width", 32'(prev_done), 32'd0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got a done pulse, required none");
          end else begin
            e = exp_q.pop_front();
            chk("sweep_cycles", busy_cnt, e.dur);
            chk("ping_timeout", 32'(ping_timeout_o), 32'(e.tmo));
            chk("integ_sticky", 32'(integ_fail_sticky_o), 32'(e.integ));
            chk("esc_en", 32'(esc_en_o), 32'(e.esc));
            chk("ch_order", ord, e.ord);
          end
          busy_cnt = 0;
          ord      = 0;
          last     = -1;
        end
        prev_done = ping_done_o;
      end
    end
  end

  task automatic clear_faults();
    resp_err_pi = '0;
    resp_err_ni = '0;
    esc_err_pi  = '0;
    esc_err_ni  = '0;
    esc_en_i    = '0;
  endtask

  // ws holds two bits per channel selecting the faulted wire: resp P, resp N, esc P, esc N.
  task automatic run_sweep(input logic [NCH-1:0] fm, input logic [2*NCH-1:0] ws,
                           input logic [NCH-1:0] em, input int unsigned t, input int restart);
    for (int c = 0; c < NCH; c++) begin
      if (fm[c]) begin
        case (ws[2*c +: 2])
          2'd0:    resp_err_pi[c] = 1'b1;
          2'd1:    resp_err_ni[c] = 1'b1;
          2'd2:    esc_err_pi[c]  = 1'b1;
          default: esc_err_ni[c]  = 1'b1;
        endcase
      end
    end
    esc_en_i       = em;
    ping_timeout_i = TW'(t);
    cyc(6);
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    exp_q.push_back(model(fm, em, t));
    n_sweeps++;
    ping_start_i = 1'b1;
    cyc(1);
    ping_start_i = 1'b0;
    chk("start_to_busy", 32'(ping_busy_o), 32'd1);
    if (restart > 0) begin
      cyc(restart);
      ping_start_i = 1'b1;
      cyc(1);
      ping_start_i = 1'b0;
    end
    for (int k = 0; k < 1000 && ping_busy_o; k++) cyc(1);
    chk("sweep_end", 32'(ping_busy_o), 32'd0);
    clear_faults();
    cyc(6);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(ping_busy_o), 32'd0);
    chk({tag, "_done"}, 32'(ping_done_o), 32'd0);
    chk({tag, "_ch"}, 32'(ping_ch_o), 32'd0);
    chk({tag, "_tmo"}, 32'(ping_timeout_o), 32'd0);
    chk({tag, "_sticky"}, 32'(integ_fail_sticky_o), 32'd0);
    chk({tag, "_esc_en"}, 32'(esc_en_o), 32'd0);
    chk({tag, "_integ"}, 32'(integ_fail_o), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [NCH-1:0]   fm, em;
    logic [2*NCH-1:0] ws;
    int unsigned      t;
    int               rs;
    int               done_snap;

    rst_n          = 1'b0;
    clear_faults();
    ping_start_i   = 1'b0;
    clr_i          = 1'b0;
    ping_timeout_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Healthy sweep, held response fault on ch2, and ch0 skipped by escalation.
    run_sweep(4'b0000, 8'h00, 4'b0000, 32, 0);
    run_sweep(4'b0100, 8'h00, 4'b0000, 16, 0);
    run_sweep(4'b0000, 8'h00, 4'b0001, 32, 0);

    // Timeout boundaries around the healthy ping latency (T=3 is a tie that ping_ok wins).
    run_sweep(4'b0000, 8'h00, 4'b0000, 3, 0);
    run_sweep(4'b0000, 8'h00, 4'b0000, 2, 0);
    run_sweep(4'b0000, 8'h00, 4'b0000, 1, 0);
    run_sweep(4'b0000, 8'h00, 4'b0000, 0, 0);

    // A start pulse while busy must be ignored.
    run_sweep(4'b0000, 8'h00, 4'b0000, 20, 5);

    // Single-cycle escalation-wire glitch while idle, then clear/set priority.
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    esc_err_ni[1] = 1'b1;
    cyc(1);
    esc_err_ni[1] = 1'b0;
    @(negedge clk);
    chk("integ_raw", 32'(integ_fail_o), 32'h2);
    @(negedge clk);
    chk("integ_latch", 32'(integ_fail_sticky_o), 32'h2);
    cyc(1);
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    @(negedge clk);
    chk("clr_alone_1", 32'(integ_fail_sticky_o), 32'h0);
    cyc(1);
    esc_err_ni[1] = 1'b1;
    cyc(1);
    esc_err_ni[1] = 1'b0;
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    @(negedge clk);
    chk("set_beats_clr", 32'(integ_fail_sticky_o), 32'h2);
    cyc(1);
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    @(negedge clk);
    chk("clr_alone_2", 32'(integ_fail_sticky_o), 32'h0);
    cyc(1);

    for (int r = 0; r < 20; r++) begin
      em = NCH'($urandom);
      fm = NCH'($urandom) & ~em;
      ws = (2*NCH)'($urandom);
      t  = (fm != '0) ? $urandom_range(1, 40) : $urandom_range(0, 40);
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_sweep(fm, ws, em, t, rs);
    end

    // Timeout disabled with ch3 faulted: the sweep parks on ch3 until reset aborts it.
    esc_err_pi[3]  = 1'b1;
    ping_timeout_i = '0;
    cyc(6);
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
    ping_start_i = 1'b1;
    cyc(1);
    ping_start_i = 1'b0;
    cyc(60);
    @(negedge clk);
    chk("stuck_busy", 32'(ping_busy_o), 32'd1);
    chk("stuck_ch", 32'(ping_ch_o), 32'd3);
    chk("stuck_tmo", 32'(ping_timeout_o), 32'd0);
    done_snap = n_done;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    cyc(2);
    clear_faults();
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    chk("no_done_on_abort", 32'(n_done), 32'(done_snap));
    chk("idle_after_abort", 32'(ping_busy_o), 32'd0);

    chk("done_count", 32'(n_done), 32'(n_sweeps));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
